// File: rtl/irq_capture_sequencer.sv
// Captures 27 interrupt request lines into pending bits and hands frozen snapshots to an external
// priority decoder. The winning vector goes out on a valid/ready port, and its pending bit is cleared on acknowledge.
module irq_capture_sequencer #(
  parameter int         EDGE_MODE = 1,
  parameter int         DEC_LAT   = 2,
  parameter logic [8:0] EN_RESET  = 9'h1FF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [26:0] irq_in,
  input  logic        cfg_we,
  input  logic [8:0]  cfg_en,
  output logic [8:0]  dec_req_a,
  output logic [8:0]  dec_req_b,
  output logic [8:0]  dec_req_c,
  output logic [8:0]  dec_en,
  input  logic        dec_pa,
  input  logic        dec_pb,
  input  logic        dec_pc,
  input  logic [3:0]  dec_chan,
  output logic        irq_valid,
  input  logic        irq_ready,
  output logic [1:0]  irq_bus,
  output logic [3:0]  irq_chan,
  output logic [26:0] pending,
  output logic        err
);

  // Handshake: a vector transfers on a rising clk edge where irq_valid and irq_ready are both high.
  // irq_valid, irq_bus and irq_chan hold steady until that edge. irq_ready never feeds an output combinationally.
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SETTLE  = 2'd1;
  localparam logic [1:0] PRESENT = 2'd2;
  localparam logic [1:0] CLEAR   = 2'd3;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [26:0] irq_q;
  logic [26:0] set;
  logic [26:0] clr;
  logic [26:0] en_all;
  logic [8:0]  en_reg;
  logic [4:0]  idx;

  always_comb begin
    set    = (EDGE_MODE != 0) ? (irq_in & ~irq_q) : irq_in;
    idx    = ({3'b000, irq_bus} * 5'd9) + {1'b0, irq_chan};
    clr    = (state == CLEAR) ? (27'd1 << idx) : 27'd0;
    en_all = {en_reg, en_reg, en_reg};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      irq_q     <= 27'd0;
      pending   <= 27'd0;
      en_reg    <= EN_RESET;
      dec_req_a <= 9'd0;
      dec_req_b <= 9'd0;
      dec_req_c <= 9'd0;
      dec_en    <= EN_RESET;
      irq_valid <= 1'b0;
      irq_bus   <= 2'd0;
      irq_chan  <= 4'd0;
      err       <= 1'b0;
    end else begin
      irq_q   <= irq_in;
      // A new capture wins over the clear of the same bit.
      pending <= (pending & ~clr) | set;
      if (cfg_we) en_reg <= cfg_en;
      case (state)
        IDLE: begin
          dec_req_a <= pending[8:0];
          dec_req_b <= pending[17:9];
          dec_req_c <= pending[26:18];
          dec_en    <= en_reg;
          if (|(pending & en_all)) begin
            state <= SETTLE;
            cnt   <= 4'd0;
          end
        end
        SETTLE: begin
          cnt <= cnt + 4'd1;
          if (cnt == 4'(DEC_LAT - 1)) begin
            if (!(dec_pa || dec_pb || dec_pc)) begin
              state <= IDLE;
            end else if (dec_chan > 4'd8) begin
              err   <= 1'b1;
              state <= IDLE;
            end else begin
              irq_bus   <= dec_pa ? 2'd0 : (dec_pb ? 2'd1 : 2'd2);
              irq_chan  <= dec_chan;
              irq_valid <= 1'b1;
              state     <= PRESENT;
            end
          end
        end
        PRESENT: begin
          if (irq_ready) begin
            irq_valid <= 1'b0;
            state     <= CLEAR;
          end
        end
        CLEAR:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_capture_sequencer.sv
// Bench for irq_capture_sequencer: a behavioural priority decoder plus a vector scoreboard.
// Directed scenarios are followed by randomized bursts of simultaneous requests.
module tb_irq_capture_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [26:0] irq_in;
  logic        cfg_we;
  logic [8:0]  cfg_en;
  logic [8:0]  dec_req_a, dec_req_b, dec_req_c, dec_en;
  logic        dec_pa, dec_pb, dec_pc;
  logic [3:0]  dec_chan;
  logic        irq_valid, irq_ready;
  logic [1:0]  irq_bus;
  logic [3:0]  irq_chan;
  logic [26:0] pending;
  logic        err;

  logic        fault = 1'b0;
  logic        use_rnd = 1'b0;
  logic        rnd_ready = 1'b0;
  logic        dir_ready = 1'b0;
  logic [5:0]  exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  logic        prev_valid = 1'b0;
  logic        prev_hs = 1'b0;

  assign irq_ready = use_rnd ? rnd_ready : dir_ready;

  always #5 clk = ~clk;

  irq_capture_sequencer dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .cfg_we(cfg_we), .cfg_en(cfg_en),
    .dec_req_a(dec_req_a), .dec_req_b(dec_req_b), .dec_req_c(dec_req_c), .dec_en(dec_en),
    .dec_pa(dec_pa), .dec_pb(dec_pb), .dec_pc(dec_pc), .dec_chan(dec_chan),
    .irq_valid(irq_valid), .irq_ready(irq_ready), .irq_bus(irq_bus), .irq_chan(irq_chan),
    .pending(pending), .err(err)
  );

  // Reference decoder: bus A outranks B, which outranks C; the lowest enabled channel wins within a bus.
  logic [8:0] ma, mb, mc, msel;
  always_comb begin
    ma = dec_req_a & dec_en;
    mb = dec_req_b & dec_en;
    mc = dec_req_c & dec_en;
    dec_pa = |ma;
    dec_pb = |mb;
    dec_pc = |mc;
    msel = dec_pa ? ma : (dec_pb ? mb : mc);
    dec_chan = 4'd0;
    for (int i = 8; i >= 0; i--) if (msel[i]) dec_chan = 4'(i);
    if (fault) begin
      dec_pa = 1'b1;
      dec_chan = 4'd12;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    rnd_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push_set(input logic [26:0] v);
    for (int b = 0; b < 3; b++)
      for (int i = 0; i < 9; i++)
        if (v[b*9+i]) exp_q.push_back({2'(b), 4'(i)});
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
        prev_hs = 1'b0;
      end else begin
        if (prev_valid && !prev_hs) check("valid_held", {31'd0, irq_valid}, 32'd1);
        if (irq_valid) begin
          if (exp_q.size() == 0) check("unexpected_vector", {26'd0, irq_bus, irq_chan}, 32'h3f);
          else begin
            check("vector", {26'd0, irq_bus, irq_chan}, {26'd0, exp_q[0]});
            if (irq_ready) void'(exp_q.pop_front());
          end
        end
        prev_valid = irq_valid;
        prev_hs = irq_valid && irq_ready;
      end
    end
  endtask

  task automatic pulse(input logic [26:0] v);
    @(posedge clk); #1; irq_in = v;
    @(posedge clk); #1; irq_in = 27'd0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (!(exp_q.size() == 0 && !irq_valid && pending == 27'd0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", {31'd0, n < budget}, 32'd1);
    check("drain_queue", exp_q.size(), 32'd0);
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!irq_valid && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_valid", {31'd0, irq_valid}, 32'd1);
  endtask

  task automatic count_valid(input int cycles, output int seen);
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (irq_valid) seen++;
    end
  endtask

  initial begin
    int seen;
    logic [26:0] v;
    rst = 1'b1; irq_in = 27'h7FFFFFF; cfg_we = 1'b0; cfg_en = 9'd0;
    fork monitor(); join_none

    // Reset with all lines high, then every line registers as a fresh edge.
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    @(negedge clk);
    check("rst_pending", pending, 0);
    check("rst_valid", {31'd0, irq_valid}, 0);
    check("rst_bus_chan", {26'd0, irq_bus, irq_chan}, 0);
    check("rst_dec_req", {5'd0, dec_req_a, dec_req_b, dec_req_c}, 0);
    check("rst_dec_en", {23'd0, dec_en}, 32'h1FF);
    check("rst_err", {31'd0, err}, 0);
    push_set(27'h7FFFFFF);
    @(posedge clk); #1; irq_in = 27'd0;
    check("edge_after_rst", pending, 32'h7FFFFFF);
    use_rnd = 1'b1;
    drain(2000);
    use_rnd = 1'b0;

    // Single request on bus B channel 5: latency, hold, and clear timing.
    exp_q.push_back({2'd1, 4'd5});
    @(posedge clk); #1; irq_in[14] = 1'b1;
    @(posedge clk); #1; irq_in = 27'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("latency_valid", {31'd0, irq_valid}, (i == 3) ? 32'd1 : 32'd0);
    end
    check("single_vec", {26'd0, irq_bus, irq_chan}, {26'd0, 2'd1, 4'd5});
    repeat (4) @(negedge clk);
    @(posedge clk); #1; dir_ready = 1'b1;
    @(posedge clk); #1; dir_ready = 1'b0;
    @(negedge clk); check("pend14_before_clr", {31'd0, pending[14]}, 1);
    @(negedge clk); check("pend14_cleared", {31'd0, pending[14]}, 0);
    drain(50);

    // Priority and ordering.
    exp_q.push_back({2'd0, 4'd3});
    exp_q.push_back({2'd2, 4'd0});
    dir_ready = 1'b1;
    pulse(27'h0040008);
    drain(100);
    dir_ready = 1'b0;

    // Masking holds the request pending without a vector until re-enabled.
    @(posedge clk); #1; cfg_we = 1'b1; cfg_en = 9'h1F7;
    @(posedge clk); #1; cfg_we = 1'b0;
    pulse(27'h8);
    count_valid(20, seen);
    check("mask_no_valid", seen, 0);
    check("mask_pending", {31'd0, pending[3]}, 1);
    exp_q.push_back({2'd0, 4'd3});
    dir_ready = 1'b1;
    @(posedge clk); #1; cfg_we = 1'b1; cfg_en = 9'h1FF;
    @(posedge clk); #1; cfg_we = 1'b0;
    drain(100);
    dir_ready = 1'b0;

    // Decoder protocol error: sticky err, no vector, pending untouched.
    fault = 1'b1;
    pulse(27'h80);
    count_valid(20, seen);
    check("err_set", {31'd0, err}, 1);
    check("err_no_valid", seen, 0);
    check("err_pending", pending, 32'h80);
    exp_q.push_back({2'd0, 4'd7});
    fault = 1'b0;
    dir_ready = 1'b1;
    drain(100);
    dir_ready = 1'b0;
    check("err_sticky", {31'd0, err}, 1);

    // New edge during CLEAR of the same bit.
    exp_q.push_back({2'd1, 4'd5});
    exp_q.push_back({2'd1, 4'd5});
    pulse(27'h4000);
    wait_valid(50);
    dir_ready = 1'b1;
    @(posedge clk); #1; dir_ready = 1'b0; irq_in[14] = 1'b1;
    @(posedge clk); #1; irq_in = 27'd0;
    @(negedge clk); check("set_wins_clear", {31'd0, pending[14]}, 1);
    dir_ready = 1'b1;
    drain(100);
    dir_ready = 1'b0;

    // Reset during PRESENT aborts the vector.
    pulse(27'h20);
    wait_valid(50);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("rst_present_valid", {31'd0, irq_valid}, 0);
    check("rst_present_pending", pending, 0);
    check("rst_present_err", {31'd0, err}, 0);

    // Random bursts of simultaneous requests with random consumer backpressure.
    use_rnd = 1'b1;
    for (int it = 0; it < 15; it++) begin
      v = 27'($urandom());
      if (v == 27'd0) v = 27'd1;
      push_set(v);
      pulse(v);
      drain(1500);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
